sm_accumulator: RTL and testbench

Sequential accumulator for 8-bit signed-magnitude samples. It sits around the combinational signed-magnitude adder stage: it drives that adder's A/B operands, takes its sum/carry back, and registers the result. It takes a packetised sample stream with valid/ready and emits one saturated, normalised signed-magnitude total per packet. It also reports a sticky overflow flag and a beat count.

---
 rtl/sm_accumulator_if.sv | 37 +++
 rtl/sm_accumulator.sv | 100 ++++++++++
 tb/tb_sm_accumulator.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sm_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module   : sm_accumulator_if
//  Purpose  : Bundles the sample stream, result stream and external adder
//             connections of the signed-magnitude accumulator.
//             slave  = accumulator view, master = environment view.
//  Revision : 1.0  initial release
// ============================================================================
interface sm_accumulator_if;
    // Input sample stream
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    // External combinational signed-magnitude adder
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic [7:0] add_sum;
    logic       add_carry;
    // Per-packet result stream
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_ovf;
    logic [7:0] out_count;

    modport slave (
        input  in_valid, in_data, in_last, add_sum, add_carry, out_ready,
        output in_ready, add_a, add_b, out_valid, out_data, out_ovf, out_count
    );

    modport master (
        output in_valid, in_data, in_last, add_sum, add_carry, out_ready,
        input  in_ready, add_a, add_b, out_valid, out_data, out_ovf, out_count
    );
endinterface
`default_nettype wire

// File: rtl/sm_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : sm_accumulator
//  Purpose  : Accumulates a packet of 8-bit signed-magnitude samples through
//             an external adder, saturating to +/-127, and emits one
//             normalised total per packet with a sticky overflow flag and a
//             saturating beat count.
//  Revision : 1.0  initial release
// ============================================================================
module sm_accumulator (
    input  wire             clk,
    input  wire             rst_n,
    sm_accumulator_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [7:0] C_NEG_ZERO  = 8'h80;
    localparam logic [7:0] C_COUNT_MAX = 8'hFF;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_acc;
    logic       r_ovf;
    logic [7:0] r_count;

    logic       w_accept;
    logic       w_first;
    logic [7:0] w_acc_next;
    logic       w_ovf_next;
    logic [7:0] w_count_next;

    assign w_accept = bus.in_valid & bus.in_ready;
    // In IDLE the adder sees +0 as operand A, so the first beat starts fresh
    // without needing to clear acc when a packet completes.
    assign w_first  = (r_state == S_IDLE);

    assign bus.in_ready  = (r_state != S_DONE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.add_a     = w_first ? 8'h00 : r_acc;
    assign bus.add_b     = bus.in_data;
    // -0 is a legal internal value but is always presented as +0.
    assign bus.out_data  = (r_acc == C_NEG_ZERO) ? 8'h00 : r_acc;
    assign bus.out_ovf   = r_ovf;
    assign bus.out_count = r_count;

    // Next-state and datapath update for an accepted beat.
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_ovf_next   = r_ovf;
        w_count_next = r_count;

        if (w_accept) begin
            // Saturation discards the overflowed magnitude entirely.
            w_acc_next = bus.add_carry ? {bus.add_sum[7], 7'h7F} : bus.add_sum;
            w_ovf_next = w_first ? bus.add_carry : (r_ovf | bus.add_carry);
            if (w_first) begin
                w_count_next = 8'd1;
            end else if (r_count != C_COUNT_MAX) begin
                w_count_next = r_count + 8'd1;
            end
        end

        case (r_state)
            S_IDLE, S_ACCUM: begin
                if (w_accept) begin
                    w_state_next = bus.in_last ? S_DONE : S_ACCUM;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, accumulator, overflow flag and beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_acc   <= 8'h00;
            r_ovf   <= 1'b0;
            r_count <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_acc   <= w_acc_next;
            r_ovf   <= w_ovf_next;
            r_count <= w_count_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sm_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sm_accumulator
//  Purpose  : Directed self-checking bench for sm_accumulator, including a
//             behavioural signed-magnitude adder on the adder port.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sm_accumulator;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    sm_accumulator_if bus ();

    sm_accumulator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural signed-magnitude adder: magnitude carry-out on like signs,
    // larger magnitude keeps its sign on unlike signs.
    always_comb begin
        logic [7:0] mag;
        mag           = 8'h00;
        bus.add_sum   = 8'h00;
        bus.add_carry = 1'b0;
        if (bus.add_a[7] == bus.add_b[7]) begin
            mag           = {1'b0, bus.add_a[6:0]} + {1'b0, bus.add_b[6:0]};
            bus.add_sum   = {bus.add_a[7], mag[6:0]};
            bus.add_carry = mag[7];
        end else if (bus.add_a[6:0] >= bus.add_b[6:0]) begin
            bus.add_sum = {bus.add_a[7], bus.add_a[6:0] - bus.add_b[6:0]};
        end else begin
            bus.add_sum = {bus.add_b[7], bus.add_b[6:0] - bus.add_a[6:0]};
        end
    end

    // Present one beat and let it be accepted on the next rising edge.
    task automatic beat(input logic [7:0] d, input logic l);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Complete the output handshake.
    task automatic handshake;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.in_data = 8'h5A;
        #3;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
        total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL reset_out_ovf got=%b exp=0", bus.out_ovf); end
        total++; if (bus.out_count !== 8'h00) begin bad++; $display("FAIL reset_out_count got=%h exp=00", bus.out_count); end
        total++; if (bus.add_a !== 8'h00) begin bad++; $display("FAIL reset_add_a got=%h exp=00", bus.add_a); end
        total++; if (bus.add_b !== 8'h5A) begin bad++; $display("FAIL reset_add_b got=%h exp=5a", bus.add_b); end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_pre_valid got=%b exp=0", bus.out_valid); end
        beat(8'h05, 1'b1);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", bus.out_valid); end
        total++; if (bus.out_data !== 8'h05) begin bad++; $display("FAIL single_data got=%h exp=05", bus.out_data); end
        total++; if (bus.out_count !== 8'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", bus.out_count); end
        total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL single_ovf got=%b exp=0", bus.out_ovf); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL single_in_ready got=%b exp=0", bus.in_ready); end
        handshake();
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL single_after_hs got valid=%b ready=%b exp valid=0 ready=1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_mixed;
        beat(8'h05, 1'b0);
        total++; if (bus.add_a !== 8'h05) begin bad++; $display("FAIL mixed_add_a got=%h exp=05", bus.add_a); end
        beat(8'h83, 1'b0);
        beat(8'h0A, 1'b1);
        total++; if (bus.out_data !== 8'h0C) begin bad++; $display("FAIL mixed_data got=%h exp=0c", bus.out_data); end
        total++; if (bus.out_count !== 8'd3) begin bad++; $display("FAIL mixed_count got=%0d exp=3", bus.out_count); end
        total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL mixed_ovf got=%b exp=0", bus.out_ovf); end
        handshake();
    endtask

    task automatic test_overflow_clear;
        beat(8'h7F, 1'b0);
        beat(8'h01, 1'b1);
        total++; if (bus.out_data !== 8'h7F) begin bad++; $display("FAIL ovf_data got=%h exp=7f", bus.out_data); end
        total++; if (bus.out_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=1", bus.out_ovf); end
        handshake();
        beat(8'h01, 1'b1);
        total++; if (bus.out_data !== 8'h01) begin bad++; $display("FAIL ovf_clear_data got=%h exp=01", bus.out_data); end
        total++; if (bus.out_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear_flag got=%b exp=0", bus.out_ovf); end
        handshake();
    endtask

    task automatic test_neg_sat;
        beat(8'hC0, 1'b0);
        beat(8'hC0, 1'b0);
        total++; if (bus.out_data !== 8'hFF) begin bad++; $display("FAIL negsat_mid_data got=%h exp=ff", bus.out_data); end
        total++; if (bus.out_ovf !== 1'b1) begin bad++; $display("FAIL negsat_mid_ovf got=%b exp=1", bus.out_ovf); end
        beat(8'h01, 1'b1);
        total++; if (bus.out_data !== 8'hFE) begin bad++; $display("FAIL negsat_data got=%h exp=fe", bus.out_data); end
        total++; if (bus.out_ovf !== 1'b1) begin bad++; $display("FAIL negsat_ovf got=%b exp=1", bus.out_ovf); end
        total++; if (bus.out_count !== 8'd3) begin bad++; $display("FAIL negsat_count got=%0d exp=3", bus.out_count); end
        handshake();
    endtask

    task automatic test_neg_zero;
        beat(8'h80, 1'b0);
        beat(8'h80, 1'b1);
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL negzero_a_data got=%h exp=00", bus.out_data); end
        handshake();
        beat(8'h85, 1'b0);
        total++; if (bus.out_data !== 8'h85) begin bad++; $display("FAIL negzero_mid_data got=%h exp=85", bus.out_data); end
        beat(8'h05, 1'b1);
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL negzero_b_data got=%h exp=00", bus.out_data); end
        handshake();
    endtask

    task automatic test_backpressure;
        beat(8'h03, 1'b1);
        // Junk offered while in DONE must be ignored.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h10;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h03 || bus.in_ready !== 1'b0 || bus.out_count !== 8'd1) begin
                bad++; $display("FAIL bp_hold[%0d] got valid=%b data=%h ready=%b count=%0d exp valid=1 data=03 ready=0 count=1",
                                i, bus.out_valid, bus.out_data, bus.in_ready, bus.out_count);
            end
            @(posedge clk); #1;
        end
        handshake();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", bus.out_valid, bus.in_ready); end
        @(posedge clk); #1;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_no_accept got valid=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_reset_mid_packet;
        beat(8'h11, 1'b0);
        beat(8'h22, 1'b0);
        rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid got valid=%b ready=%b exp valid=0 ready=1", bus.out_valid, bus.in_ready); end
        total++; if (bus.out_count !== 8'd0 || bus.out_data !== 8'h00 || bus.add_a !== 8'h00) begin
            bad++; $display("FAIL rst_mid_regs got count=%0d data=%h add_a=%h exp 0/00/00", bus.out_count, bus.out_data, bus.add_a);
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        beat(8'h02, 1'b1);
        total++; if (bus.out_data !== 8'h02) begin bad++; $display("FAIL rst_fresh_data got=%h exp=02", bus.out_data); end
        total++; if (bus.out_count !== 8'd1) begin bad++; $display("FAIL rst_fresh_count got=%0d exp=1", bus.out_count); end
        handshake();
    endtask

    task automatic test_long_packet;
        for (int i = 0; i < 300; i++) begin
            beat(8'h00, (i == 299) ? 1'b1 : 1'b0);
        end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL long_valid got=%b exp=1", bus.out_valid); end
        total++; if (bus.out_count !== 8'd255) begin bad++; $display("FAIL long_count got=%0d exp=255", bus.out_count); end
        total++; if (bus.out_data !== 8'h00 || bus.out_ovf !== 1'b0) begin bad++; $display("FAIL long_data got data=%h ovf=%b exp 00/0", bus.out_data, bus.out_ovf); end
        handshake();
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_mixed();
        test_overflow_clear();
        test_neg_sat();
        test_neg_zero();
        test_backpressure();
        test_reset_mid_packet();
        test_long_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
